multicycle_controller: RTL

Main control FSM for the multi-cycle RV32I processor core. It sequences instruction fetch, decode, execute, memory access and write-back over several clock cycles on a shared datapath with one ALU and one unified memory port. It replaces single-cycle combinational decode with per-state control strobes and adds a ready-based wait handshake to memory. It sits between the instruction register/flags and the datapath multiplexer selects and write enables.

---
 rtl/rv_ctrl_pkg.sv | 84 ++++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// ALU operations, datapath select codes and immediate formats.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2   = 2'b00,
        SRCB_IMM   = 2'b01,
        SRCB_FOUR  = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALU    = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic imm_src_e immSrcFor(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus instruction function fields onto
// the concrete ALU operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    // op[5] separates R-type from I-ALU so addi never becomes a subtract.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default:   alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and write-back with a ready handshake on the memory port.
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [2:0] imm_src_o,
    output logic [2:0] alu_control_o,
    output logic       illegal_o,
    output logic [3:0] state_dbg_o
);

    state_e     state_q, state_d;
    logic [1:0] aluOp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH:              state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore strobes per state; only the FETCH/BRANCH register writes look at inputs.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RS2;
        result_src_o = RES_ALUOUT;
        aluOp        = ALUOP_ADD;
        illegal_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWB: begin
                result_src_o = RES_DATA;
                reg_write_o  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_o = SRCA_RS1;
                aluOp       = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                aluOp       = ALUOP_FUNCT;
            end
            S_ALUWB:  reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = SRCA_RS1;
                aluOp       = ALUOP_SUB;
                pc_write_o  = ((funct3_i == 3'b000) && zero_i) ||
                              ((funct3_i == 3'b001) && !zero_i);
            end
            S_JAL: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_write_o  = 1'b1;
            end
            S_LUI: begin
                alu_src_a_o = SRCA_ZERO;
                alu_src_b_o = SRCB_IMM;
            end
            S_AUIPC: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
            end
            S_TRAP:   illegal_o = 1'b1;
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (aluOp),
        .funct3_i      (funct3_i),
        .funct7b5_i    (funct7b5_i),
        .op5_i         (op_i[5]),
        .alu_control_o (alu_control_o)
    );

    assign imm_src_o   = immSrcFor(op_i);
    assign state_dbg_o = state_q;

endmodule
